// File: rtl/pc_select.sv
// rtl/pc_select.sv - Y86-64 next-PC selection with static jump prediction, ret wait and halt freeze
// Optional backward-taken/forward-not-taken jxx prediction: define PC_SELECT_BTFN_EN.

module pc_select_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

module pc_select #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      pc_out,
    input  logic [3:0]       f_icode,
    input  logic             f_valid,
    input  logic [63:0]      f_valc,
    input  logic [63:0]      f_valp,
    input  logic             stall_f,
    input  logic             m_mispredict,
    input  logic [63:0]      m_vala,
    input  logic             w_ret,
    input  logic [63:0]      w_valm,
    output logic [63:0]      pc_in,
    output logic             fetch_hold,
    output logic             redirect,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] ret_stall_cnt
);

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        jxx_taken;
    logic [63:0] predict_pc;
    state_t      predict_state;
    logic        mis_inc;
    logic        ret_inc;

`ifdef PC_SELECT_BTFN_EN
    // Backward branches (loops) are the ones worth predicting taken.
    assign jxx_taken = (f_valc <= pc_out);
`else
    assign jxx_taken = 1'b1;
`endif

    // Static prediction for the instruction currently being fetched.
    always_comb begin
        predict_pc    = f_valp;
        predict_state = ST_RUN;
        if (!f_valid || (f_icode == ICODE_HALT)) begin
            predict_pc    = pc_out;
            predict_state = ST_HALT;
        end else begin
            case (f_icode)
                ICODE_RET: begin
                    predict_pc    = f_valp;
                    predict_state = ST_RET_WAIT;
                end
                ICODE_CALL: predict_pc = f_valc;
                ICODE_JXX:  predict_pc = jxx_taken ? f_valc : f_valp;
                default:    predict_pc = f_valp;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        pc_in      = pc_out;
        fetch_hold = 1'b0;
        redirect   = 1'b0;
        state_nxt  = state;
        mis_inc    = 1'b0;
        ret_inc    = 1'b0;

        if (reset) begin
            pc_in     = 64'd0;
            state_nxt = ST_RUN;
        end else if (m_mispredict) begin
            // A mispredict also cancels any wrong-path ret or halt.
            pc_in     = m_vala;
            redirect  = 1'b1;
            state_nxt = ST_RUN;
            mis_inc   = 1'b1;
        end else begin
            case (state)
                ST_RET_WAIT: begin
                    if (w_ret) begin
                        pc_in     = w_valm;
                        redirect  = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        pc_in      = pc_out;
                        fetch_hold = 1'b1;
                        ret_inc    = 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_in      = pc_out;
                    fetch_hold = 1'b1;
                end
                ST_RUN: begin
                    if (stall_f) begin
                        pc_in = pc_out;
                    end else begin
                        pc_in     = predict_pc;
                        state_nxt = predict_state;
                    end
                end
                default: begin
                    pc_in      = pc_out;
                    fetch_hold = 1'b1;
                    state_nxt  = ST_RUN;
                end
            endcase
        end
    end

    pc_select_sat_cnt #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mis_inc),
        .count (mispredict_cnt)
    );

    pc_select_sat_cnt #(.W(CNT_W)) u_ret_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ret_inc),
        .count (ret_stall_cnt)
    );

endmodule

// File: tb/tb_pc_select.sv
// tb/tb_pc_select.sv - self-checking bench for pc_select against a cycle-level behavioural model

module tb_pc_select;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_RUN   = 0;
    localparam int M_RET   = 1;
    localparam int M_HALT  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [63:0]      pc_out;
    logic [3:0]       f_icode;
    logic             f_valid;
    logic [63:0]      f_valc;
    logic [63:0]      f_valp;
    logic             stall_f;
    logic             m_mispredict;
    logic [63:0]      m_vala;
    logic             w_ret;
    logic [63:0]      w_valm;
    logic [63:0]      pc_in;
    logic             fetch_hold;
    logic             redirect;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] ret_stall_cnt;

    int  tests = 0;
    int  fails = 0;
    bit  started = 0;
    int  m_mode = M_RUN;
    int  m_mcnt = 0;
    int  m_rcnt = 0;

    pc_select #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_out         (pc_out),
        .f_icode        (f_icode),
        .f_valid        (f_valid),
        .f_valc         (f_valc),
        .f_valp         (f_valp),
        .stall_f        (stall_f),
        .m_mispredict   (m_mispredict),
        .m_vala         (m_vala),
        .w_ret          (w_ret),
        .w_valm         (w_valm),
        .pc_in          (pc_in),
        .fetch_hold     (fetch_hold),
        .redirect       (redirect),
        .mispredict_cnt (mispredict_cnt),
        .ret_stall_cnt  (ret_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Spec rules evaluated on the current inputs and model mode.
    task automatic model_eval(output logic [63:0] e_pc, output logic e_hold, output logic e_red,
                              output int e_next, output bit e_minc, output bit e_rinc);
        e_pc = pc_out; e_hold = 0; e_red = 0; e_next = m_mode; e_minc = 0; e_rinc = 0;
        if (reset) begin
            e_pc = 0; e_next = M_RUN;
        end else if (m_mispredict) begin
            e_pc = m_vala; e_red = 1; e_next = M_RUN; e_minc = 1;
        end else if (m_mode == M_RET && w_ret) begin
            e_pc = w_valm; e_red = 1; e_next = M_RUN;
        end else if (m_mode == M_RET) begin
            e_hold = 1; e_rinc = 1;
        end else if (m_mode == M_HALT) begin
            e_hold = 1;
        end else if (!stall_f) begin
            if (!f_valid || f_icode == 4'h0) e_next = M_HALT;
            else if (f_icode == 4'h9) begin e_pc = f_valp; e_next = M_RET; end
            else if (f_icode == 4'h8) e_pc = f_valc;
`ifdef PC_SELECT_BTFN_EN
            else if (f_icode == 4'h7) e_pc = (f_valc <= pc_out) ? f_valc : f_valp;
`else
            else if (f_icode == 4'h7) e_pc = f_valc;
`endif
            else e_pc = f_valp;
        end
    endtask

    always @(posedge clk) begin
        logic [63:0] e_pc;
        logic e_hold, e_red;
        int e_next;
        bit e_minc, e_rinc;
        model_eval(e_pc, e_hold, e_red, e_next, e_minc, e_rinc);
        m_mode = e_next;
        if (reset) begin
            m_mcnt = 0; m_rcnt = 0;
        end else begin
            if (e_minc && m_mcnt < CNT_MAX) m_mcnt++;
            if (e_rinc && m_rcnt < CNT_MAX) m_rcnt++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        logic [63:0] e_pc;
        logic e_hold, e_red;
        int e_next;
        bit e_minc, e_rinc;
        if (started) begin
            model_eval(e_pc, e_hold, e_red, e_next, e_minc, e_rinc);
            check("model_pc_in", pc_in, e_pc);
            check("model_fetch_hold", {63'd0, fetch_hold}, {63'd0, e_hold});
            check("model_redirect", {63'd0, redirect}, {63'd0, e_red});
            check("model_mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
            check("model_ret_stall_cnt", 64'(ret_stall_cnt), 64'(m_rcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; f_icode = 4'h1; f_valid = 1; f_valc = 0; f_valp = 0;
        stall_f = 0; m_mispredict = 0; m_vala = 0; w_ret = 0; w_valm = 0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] pc, input logic [63:0] valc,
                         input logic [63:0] valp);
        idle();
        f_icode = ic; pc_out = pc; f_valc = valc; f_valp = valp;
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] e_pc, input logic e_hold, input logic e_red);
        check({name, "_pc_in"}, pc_in, e_pc);
        check({name, "_hold"}, {63'd0, fetch_hold}, {63'd0, e_hold});
        check({name, "_redirect"}, {63'd0, redirect}, {63'd0, e_red});
    endtask

    initial begin
        idle();
        pc_out = 64'h0;
        reset = 1;
        tick();
        lit("reset", 64'h0, 0, 0);
        check("reset_mcnt", 64'(mispredict_cnt), 64'd0);
        check("reset_rcnt", 64'(ret_stall_cnt), 64'd0);
        tick();

        fetch(4'h6, 64'h10, 64'h0, 64'h12);   lit("opq", 64'h12, 0, 0); tick();
        fetch(4'h8, 64'h12, 64'h200, 64'h1b); lit("call", 64'h200, 0, 0); tick();
        fetch(4'h7, 64'h80, 64'h40, 64'h89);  lit("jxx_back", 64'h40, 0, 0); tick();
        fetch(4'h7, 64'h80, 64'h100, 64'h89);
`ifdef PC_SELECT_BTFN_EN
        lit("jxx_fwd", 64'h89, 0, 0);
`else
        lit("jxx_fwd", 64'h100, 0, 0);
`endif
        tick();
        fetch(4'h7, 64'h80, 64'h80, 64'h89);  lit("jxx_equal", 64'h80, 0, 0); tick();

        fetch(4'h9, 64'h30, 64'h0, 64'h31);   lit("ret_fetch", 64'h31, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            fetch(4'h6, 64'h31, 64'h0, 64'h33); lit("ret_wait", 64'h31, 1, 0); tick();
        end
        fetch(4'h6, 64'h31, 64'h0, 64'h33);
        w_ret = 1; w_valm = 64'h500; #1;
        lit("ret_resolve", 64'h500, 0, 1);
        check("ret_rcnt3", 64'(ret_stall_cnt), 64'd3);
        tick();

        fetch(4'h9, 64'h500, 64'h0, 64'h501); tick();
        fetch(4'h6, 64'h501, 64'h0, 64'h503);
        m_mispredict = 1; m_vala = 64'h88; w_ret = 1; w_valm = 64'h600; #1;
        lit("mis_vs_ret", 64'h88, 0, 1);
        tick();
        fetch(4'h6, 64'h88, 64'h0, 64'h8a);   lit("after_mis", 64'h8a, 0, 0);
        check("mis_mcnt1", 64'(mispredict_cnt), 64'd1);
        check("mis_rcnt3", 64'(ret_stall_cnt), 64'd3);
        tick();

        fetch(4'h0, 64'h8a, 64'h0, 64'h8b);   lit("halt_fetch", 64'h8a, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            fetch(4'($urandom_range(0, 15)), 64'h8a, 64'h0, 64'($urandom));
            w_ret = 1'($urandom_range(0, 1)); stall_f = 1'($urandom_range(0, 1));
            w_valm = 64'($urandom); #1;
            lit("halt_hold", 64'h8a, 1, 0);
            tick();
        end
        fetch(4'h6, 64'h8a, 64'h0, 64'h8c);
        reset = 1; #1;
        lit("reset_halt", 64'h0, 0, 0);
        tick();
        fetch(4'h1, 64'h0, 64'h0, 64'h1);     lit("post_reset", 64'h1, 0, 0);
        check("post_reset_mcnt", 64'(mispredict_cnt), 64'd0);
        check("post_reset_rcnt", 64'(ret_stall_cnt), 64'd0);
        tick();

        fetch(4'h6, 64'h40, 64'h0, 64'h42);
        f_valid = 0; #1;
        lit("invalid_fetch", 64'h40, 0, 0);
        tick();
        fetch(4'h6, 64'h40, 64'h0, 64'h42);
        m_mispredict = 1; m_vala = 64'h44; #1;
        lit("halt_mis", 64'h44, 0, 1);
        tick();

        fetch(4'h9, 64'h44, 64'h0, 64'h45);
        stall_f = 1; #1;
        lit("stall_ret", 64'h44, 0, 0);
        tick();
        fetch(4'h9, 64'h44, 64'h0, 64'h45);   lit("unstall_ret", 64'h45, 0, 0); tick();
        for (int i = 0; i < 9; i++) begin
            fetch(4'h6, 64'h45, 64'h0, 64'h47);
            stall_f = 1'($urandom_range(0, 1)); #1;
            lit("ret_wait_long", 64'h45, 1, 0);
            tick();
        end
        check("rcnt_saturate", 64'(ret_stall_cnt), 64'(CNT_MAX));
        fetch(4'h6, 64'h45, 64'h0, 64'h47);
        stall_f = 1; w_ret = 1; w_valm = 64'h700; #1;
        lit("stall_ret_resolve", 64'h700, 0, 1);
        tick();

        for (int i = 0; i < 8; i++) begin
            fetch(4'h6, 64'h700 + 64'(i), 64'h0, 64'h702);
            stall_f = 1; m_mispredict = 1; m_vala = 64'h900 + 64'(i); #1;
            lit("mis_burst", 64'h900 + 64'(i), 0, 1);
            tick();
        end
        check("mcnt_saturate", 64'(mispredict_cnt), 64'(CNT_MAX));
        fetch(4'h6, 64'h907, 64'h0, 64'h909);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_select.md
# pc_select

Next-PC selection unit sitting directly upstream of the `pc` register: it computes `pc_in` every cycle from the current fetch, pipeline corrections and its own control state. It implements Y86-64 fetch-side control: static jump/call prediction, `ret` wait, halt freeze, stall hold and misprediction redirect. It also keeps two saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_out`  in  64  current fetch PC from `pc` register.
- `f_icode`  in  4  icode of instruction fetched at `pc_out`.
- `f_valid`  in  1  fetch valid; 0 = imem error / invalid instruction.
- `f_valc`  in  64  constant word of fetched instruction (jump/call target).
- `f_valp`  in  64  fall-through address of fetched instruction.
- `stall_f`  in  1  pipeline control requests fetch stall.
- `m_mispredict`  in  1  jump in M stage was mispredicted.
- `m_vala`  in  64  correct PC for the mispredicted jump.
- `w_ret`  in  1  a `ret` is in W stage this cycle.
- `w_valm`  in  64  return address read by that `ret`.
- `pc_in`  out  64  next PC, feeds `pc` register (combinational).
- `fetch_hold`  out  1  fetch must inject a bubble this cycle.
- `redirect`  out  1  `pc_in` is a correction; younger stages flush.
- `mispredict_cnt`  out  CNT_W  registered count of applied mispredicts.
- `ret_stall_cnt`  out  CNT_W  registered count of cycles spent in RET_WAIT.

## Operation
- States: RUN, RET_WAIT, HALT (2-bit encoded, registered).
- Selection priority per cycle: `reset` > `m_mispredict` > (`w_ret` in RET_WAIT) > HALT/RET_WAIT hold > `stall_f` > prediction.
- `reset`: `pc_in`=0, `fetch_hold`=0, `redirect`=0; next state RUN; counters cleared.
- `m_mispredict`: `pc_in`=`m_vala`, `redirect`=1, next state RUN (from any state; wrong-path `ret`/halt is cancelled). `mispredict_cnt` increments.
- RET_WAIT with `w_ret`: `pc_in`=`w_valm`, `redirect`=1, next state RUN.
- RET_WAIT without `w_ret`: `pc_in`=`pc_out`, `fetch_hold`=1, `ret_stall_cnt` increments.
- HALT: `pc_in`=`pc_out`, `fetch_hold`=1; exits only via reset or `m_mispredict`.
- RUN with `stall_f`: `pc_in`=`pc_out`, no state change, no prediction side effects.
- RUN prediction:
  - `f_valid`=0 or icode 0 (halt) -> `pc_in`=`pc_out`, next HALT.
  - icode 9 (ret) -> `pc_in`=`f_valp`, next RET_WAIT. Fetch bubbles start on the following cycle.
  - icode 8 (call) -> `pc_in`=`f_valc`.
  - icode 7 (jxx) -> per Configuration.
  - All others -> `pc_in`=`f_valp`.
- `w_ret` while in RUN or HALT is ignored.
- Counters saturate at all-ones and do not wrap.
- Address arithmetic: none. Values pass through unchanged, and 64-bit wrap is the producer's concern.

## Timing
- `pc_in`, `fetch_hold`, `redirect` are combinational from inputs and state. The `pc` register captures `pc_in` at the next edge, so a redirect takes effect as the fetch PC one cycle later.
- State and counters update on the rising edge, with 1-cycle latency.
- `m_mispredict` and `w_ret` in the same cycle while in RET_WAIT: mispredict wins and `ret_stall_cnt` does not increment.
- Reset mid-RET_WAIT or mid-HALT: RUN on the next cycle, counters 0.
- `stall_f` does not block `m_mispredict` or `w_ret` correction.

## Configuration
- `PC_SELECT_BTFN_EN` defined: jxx is predicted taken (`f_valc`) only if `f_valc` <= `pc_out` (unsigned, backward branch). Otherwise it is predicted not taken (`f_valp`).
- Undefined: jxx is always predicted taken (`pc_in`=`f_valc`).
- Misprediction recovery is identical in both builds, because `m_vala` always carries the correct PC.

## Test plan
- Reset, then RUN with icode 6, `pc_out`=0x10, `f_valp`=0x12 -> `pc_in`=0x12, `fetch_hold`=0, `redirect`=0.
- Call: icode 8, `f_valc`=0x200 -> `pc_in`=0x200. Jxx with `f_valc`=0x40, `pc_out`=0x80:
  - both builds -> `pc_in`=0x40.
  - `f_valc`=0x100 -> 0x100 (BTFN off) or `f_valp` (BTFN on).
- Ret at `pc_out`=0x30 -> 3 held cycles with `fetch_hold`=1 and `pc_in`=0x31. Then `w_ret`, `w_valm`=0x500 -> `pc_in`=0x500, `redirect`=1, `ret_stall_cnt`=3.
- `m_mispredict` with `m_vala`=0x88 while in RET_WAIT and `w_ret`=1 -> `pc_in`=0x88, state RUN, `mispredict_cnt`=1, `ret_stall_cnt` unchanged.
- Halt (icode 0), then 5 cycles of random `w_ret`/`stall_f` -> `pc_in`=`pc_out` throughout. Then `reset` -> `pc_in`=0, counters 0.
- `stall_f`=1 with icode 9 -> `pc_in`=`pc_out`, state stays RUN. Release `stall_f` -> enters RET_WAIT.
